// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter between N_REQ byte-stream
// requesters, with burst limiting, tx_done timeout and idle-only baud config.
module uart_tx_scheduler #(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned MAX_BURST    = 16,
  parameter int unsigned WAIT_TIMEOUT = 200000,
  parameter logic [15:0] DEFAULT_CPB  = 16'd868
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic [15:0]          i_cfg_cpb,
  input  logic [N_REQ-1:0]     i_req_valid,
  input  logic [8*N_REQ-1:0]   i_req_data,
  input  logic [N_REQ-1:0]     i_req_last,
  output logic [N_REQ-1:0]     o_req_ready,
  output logic                 o_tx_start,
  output logic [7:0]           o_tx_data,
  output logic [15:0]          o_tx_cpb,
  input  logic                 i_tx_done,
  output logic [2:0]           o_grant_id,
  output logic                 o_busy,
  output logic                 o_err_timeout,
  output logic                 o_err_spurious
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned TO_W  = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEND = 2'd1, S_WAIT = 2'd2} state_t;

  state_t            r_state, w_next_state;
  logic [IDX_W-1:0]  r_grant, r_rr_ptr, w_pick, w_rel_ptr;
  logic [7:0]        r_burst_cnt;
  logic [TO_W-1:0]   r_to_cnt;
  logic              r_last_q;
  logic              r_tx_start, r_busy, r_err_timeout, r_err_spurious;
  logic [7:0]        r_tx_data;
  logic [15:0]       r_tx_cpb;
  logic              w_found, w_sel_valid, w_sel_last;
  logic [7:0]        w_sel_data;
  logic              w_grant, w_accept, w_release, w_done, w_timeout;
  logic              w_burst_end, w_to_hit;
  logic [N_REQ-1:0]  w_req_ready;

  // First valid requester searching rr_ptr, rr_ptr+1, ... (mod N_REQ)
  always_comb begin
    int slot;
    w_found = 1'b0;
    w_pick  = '0;
    slot    = 0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      slot = int'(r_rr_ptr) + k;
      if (slot >= int'(N_REQ)) slot = slot - int'(N_REQ);
      for (int i = 0; i < int'(N_REQ); i++) begin
        if (!w_found && i_req_valid[i] && slot == i) begin
          w_found = 1'b1;
          w_pick  = IDX_W'(i);
        end
      end
    end
  end

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (r_grant == IDX_W'(i)) begin
        w_sel_valid = i_req_valid[i];
        w_sel_last  = i_req_last[i];
        w_sel_data  = i_req_data[8*i +: 8];
      end
    end
  end

  assign w_rel_ptr   = (r_grant == LAST_IDX) ? '0 : r_grant + IDX_W'(1);
  assign w_burst_end = r_last_q || (({1'b0, r_burst_cnt} + 9'd1) == 9'(MAX_BURST));
  assign w_to_hit    = (r_to_cnt == TO_W'(WAIT_TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (i_en && w_found) w_next_state = S_SEND;
      S_SEND: w_next_state = w_sel_valid ? S_WAIT : S_IDLE;
      S_WAIT: begin
        if (i_tx_done)     w_next_state = w_burst_end ? S_IDLE : S_SEND;
        else if (w_to_hit) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Ready is combinational so the grantee sees it in the SEND cycle itself
  always_comb begin
    w_req_ready = '0;
    w_grant     = 1'b0;
    w_accept    = 1'b0;
    w_release   = 1'b0;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: w_grant = i_en && w_found;
      S_SEND: begin
        for (int i = 0; i < int'(N_REQ); i++) begin
          if (r_grant == IDX_W'(i)) w_req_ready[i] = i_req_valid[i] && !i_rst;
        end
        w_accept  = w_sel_valid;
        w_release = !w_sel_valid;
      end
      S_WAIT: begin
        w_done    = i_tx_done;
        w_timeout = !i_tx_done && w_to_hit;
        w_release = (i_tx_done && w_burst_end) || w_timeout;
      end
      default: w_grant = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_grant        <= '0;
      r_rr_ptr       <= '0;
      r_burst_cnt    <= '0;
      r_to_cnt       <= '0;
      r_last_q       <= 1'b0;
      r_tx_start     <= 1'b0;
      r_tx_data      <= '0;
      r_tx_cpb       <= DEFAULT_CPB;
      r_busy         <= 1'b0;
      r_err_timeout  <= 1'b0;
      r_err_spurious <= 1'b0;
    end else begin
      r_tx_start     <= w_accept;
      r_err_timeout  <= w_timeout;
      r_err_spurious <= i_tx_done && (r_state != S_WAIT);
      r_busy         <= (w_next_state != S_IDLE);
      if (r_state == S_IDLE) r_tx_cpb <= i_cfg_cpb;
      if (w_grant) begin
        r_grant     <= w_pick;
        r_burst_cnt <= '0;
      end
      if (w_accept) begin
        r_tx_data <= w_sel_data;
        r_last_q  <= w_sel_last;
      end
      if (w_done) r_burst_cnt <= r_burst_cnt + 8'd1;
      if (w_release) r_rr_ptr <= w_rel_ptr;
      // Counts WAIT cycles without a done; cleared on any exit from WAIT
      if (r_state == S_WAIT && !w_done && !w_timeout) begin
        if (r_to_cnt != {TO_W{1'b1}}) r_to_cnt <= r_to_cnt + TO_W'(1);
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

  assign o_req_ready    = w_req_ready;
  assign o_tx_start     = r_tx_start;
  assign o_tx_data      = r_tx_data;
  assign o_tx_cpb       = r_tx_cpb;
  assign o_grant_id     = 3'(r_grant);
  assign o_busy         = r_busy;
  assign o_err_timeout  = r_err_timeout;
  assign o_err_spurious = r_err_spurious;

endmodule
